// File: rtl/isa_pkg.sv
// Shared ISA definitions for the multi-cycle controller: state encodings,
// opcode/opext constants, PC source codes and instruction-class helpers.
package isa_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEMRD  = 3'd3,
      ST_MEMWR  = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_e;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_MEMJ  = 4'b0100;
   localparam logic [3:0] OP_ALT   = 4'b1000;
   localparam logic [3:0] OP_CMPI  = 4'b1011;
   localparam logic [3:0] OP_BCOND = 4'b1100;

   localparam logic [3:0] EXT_LOAD    = 4'b0000;
   localparam logic [3:0] EXT_STOR    = 4'b0100;
   localparam logic [3:0] EXT_JCOND   = 4'b1100;
   localparam logic [3:0] EXT_CMP     = 4'b1011;
   localparam logic [3:0] EXT_ALT_REG = 4'b0100;

   localparam logic [1:0] PC_SRC_INC = 2'b00;
   localparam logic [1:0] PC_SRC_REL = 2'b01;
   localparam logic [1:0] PC_SRC_REG = 2'b10;

   // Opcode 0100 is only legal for its three memory/jump sub-operations.
   function automatic logic op_legal(input logic [3:0] op, input logic [3:0] ext);
      logic ok;
      ok = 1'b0;
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001,
         4'b1011, 4'b1101, 4'b1000, 4'b1111, 4'b1100: ok = 1'b1;
         OP_MEMJ: ok = (ext == EXT_LOAD) || (ext == EXT_STOR) || (ext == EXT_JCOND);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic uses_imm(input logic [3:0] op, input logic [3:0] ext);
      return !((op == OP_RTYPE) || ((op == OP_ALT) && (ext == EXT_ALT_REG)));
   endfunction

   // Compares only update flags, so they never write the register file.
   function automatic logic wb_writes_reg(input logic [3:0] op, input logic [3:0] ext);
      return !((op == OP_CMPI) || ((op == OP_RTYPE) && (ext == EXT_CMP)));
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory handshakes; flags when the count has
// reached the configured limit.
module mem_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear_i,
   input  logic       count_en_i,
   output logic       expired_o
);

   localparam logic [3:0] LIMIT = 4'(WAIT_MAX);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = 4'd0;
      end else if (count_en_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mcycle_control.sv
// Multi-cycle instruction controller: fetch/decode/execute sequencing,
// memory handshakes with timeout, and datapath strobe generation.
module mcycle_control
   import isa_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        cond_true,
   output logic [3:0]  opcode,
   output logic [3:0]  opext,
   output logic [3:0]  rdest,
   output logic [3:0]  rsrc,
   output logic [7:0]  imm,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_sel,
   output logic        pc_en,
   output logic [1:0]  pc_src,
   output logic        regwrite,
   output logic        alusrc_imm,
   output logic        memtoreg,
   output logic        fault,
   output logic [2:0]  state_dbg
);

   state_e      state_q;
   logic [15:0] ir_q;
   logic        fault_q;

   logic in_wait;
   logic handshake;
   logic timeout;
   logic wait_expired;

   assign opcode    = ir_q[15:12];
   assign rdest     = ir_q[11:8];
   assign opext     = ir_q[7:4];
   assign rsrc      = ir_q[3:0];
   assign imm       = ir_q[7:0];
   assign fault     = fault_q;
   assign state_dbg = state_q;

   assign in_wait   = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
   assign handshake = in_wait && mem_ready;
   // A ready in the same cycle the limit is reached wins over the timeout.
   assign timeout   = in_wait && !mem_ready && wait_expired;

   // Counter is held at zero outside the wait states, so every entry starts fresh.
   mem_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (!in_wait || mem_ready),
      .count_en_i (in_wait && !mem_ready),
      .expired_o  (wait_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         ir_q    <= 16'h0000;
         fault_q <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (handshake) begin
                  ir_q    <= mem_rdata;
                  state_q <= ST_DECODE;
               end else if (timeout) begin
                  fault_q <= 1'b1;
                  state_q <= ST_HALT;
               end
            end
            ST_DECODE: begin
               if (op_legal(opcode, opext)) begin
                  state_q <= ST_EXEC;
               end else begin
                  fault_q <= 1'b1;
                  state_q <= ST_HALT;
               end
            end
            ST_EXEC: begin
               if (opcode == OP_MEMJ) begin
                  if (opext == EXT_LOAD) begin
                     state_q <= ST_MEMRD;
                  end else if (opext == EXT_STOR) begin
                     state_q <= ST_MEMWR;
                  end else begin
                     state_q <= ST_FETCH;
                  end
               end else if (opcode == OP_BCOND) begin
                  state_q <= ST_FETCH;
               end else begin
                  state_q <= ST_WB;
               end
            end
            ST_MEMRD, ST_MEMWR: begin
               if (handshake) begin
                  state_q <= ST_FETCH;
               end else if (timeout) begin
                  fault_q <= 1'b1;
                  state_q <= ST_HALT;
               end
            end
            ST_WB:   state_q <= ST_FETCH;
            ST_HALT: state_q <= ST_HALT;
            default: begin
               fault_q <= 1'b1;
               state_q <= ST_HALT;
            end
         endcase
      end
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = PC_SRC_INC;
      regwrite   = 1'b0;
      alusrc_imm = 1'b0;
      memtoreg   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            pc_en   = mem_ready;
         end
         ST_EXEC: begin
            alusrc_imm = uses_imm(opcode, opext);
            if (opcode == OP_BCOND) begin
               pc_src = PC_SRC_REL;
               pc_en  = cond_true;
            end else if ((opcode == OP_MEMJ) && (opext == EXT_JCOND)) begin
               pc_src = PC_SRC_REG;
               pc_en  = cond_true;
            end
         end
         ST_MEMRD: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            regwrite = mem_ready;
            memtoreg = mem_ready;
         end
         ST_MEMWR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            addr_sel = 1'b1;
         end
         ST_WB: regwrite = wb_writes_reg(opcode, opext);
         default: ;
      endcase
      // Strobes must be quiet for the whole time reset is held, not just after the edge.
      if (!reset) begin
         mem_req  = 1'b0;
         mem_we   = 1'b0;
         pc_en    = 1'b0;
         regwrite = 1'b0;
         memtoreg = 1'b0;
      end
   end

endmodule

// File: tb/tb_mcycle_control.sv
// Directed bench for mcycle_control: a per-cycle vector table plus
// hand-written sequences for timeout, boundary ready and reset corners.
module tb_mcycle_control;

   logic        clk;
   logic        reset;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        cond_true;
   logic [3:0]  opcode, opext, rdest, rsrc;
   logic [7:0]  imm;
   logic        mem_req, mem_we, addr_sel, pc_en;
   logic [1:0]  pc_src;
   logic        regwrite, alusrc_imm, memtoreg, fault;
   logic [2:0]  state_dbg;

   int n_tests;
   int n_fail;
   logic [15:0] ir_m;

   typedef struct {
      logic [15:0] rdata;
      logic        rdy;
      logic        cond;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[$];

   mcycle_control #(.WAIT_MAX(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .cond_true  (cond_true),
      .opcode     (opcode),
      .opext      (opext),
      .rdest      (rdest),
      .rsrc       (rsrc),
      .imm        (imm),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .addr_sel   (addr_sel),
      .pc_en      (pc_en),
      .pc_src     (pc_src),
      .regwrite   (regwrite),
      .alusrc_imm (alusrc_imm),
      .memtoreg   (memtoreg),
      .fault      (fault),
      .state_dbg  (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected bundle: {state, mem_req, mem_we, addr_sel, pc_en, pc_src, regwrite, alusrc_imm, memtoreg, fault}
   function automatic logic [12:0] e(input logic [2:0] st, input logic req, we, asel, pce,
                                     input logic [1:0] src, input logic rw, alu, m2r, flt);
      return {st, req, we, asel, pce, src, rw, alu, m2r, flt};
   endfunction

   function automatic logic [12:0] outs();
      return {state_dbg, mem_req, mem_we, addr_sel, pc_en, pc_src, regwrite, alusrc_imm, memtoreg, fault};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [15:0] d, input logic r, input logic c, input logic [12:0] x);
      vec_t v;
      v.rdata = d;
      v.rdy   = r;
      v.cond  = c;
      v.exp   = x;
      vecs.push_back(v);
   endtask

   // Drive one cycle's inputs at the falling edge, check just after, advance to next falling edge.
   task automatic apply(input string name, input logic [15:0] d, input logic r, input logic c,
                        input logic [12:0] x);
      mem_rdata = d;
      mem_ready = r;
      cond_true = c;
      #1;
      check(name, 32'(outs()), 32'(x));
      check({name, "_ir"}, {16'h0, opcode, rdest, opext, rsrc}, {16'h0, ir_m});
      check({name, "_imm"}, 32'(imm), 32'(ir_m[7:0]));
      if ((x[12:10] == 3'd0) && r) ir_m = d;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 16'h0000;
      cond_true = 1'b0;
      #1;
      check("reset_outs", 32'(outs()), 32'(e(3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0)));
      check("reset_ir", {16'h0, opcode, rdest, opext, rsrc}, 32'h0);
      ir_m = 16'h0000;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   logic [12:0] e_fh, e_fw, e_dec, e_x1, e_x0, e_wb1, e_wb0;

   task automatic add_fd(input logic [15:0] d);
      add(d, 1'b1, 1'b0, e_fh);
      add(16'hFFFF, 1'b0, 1'b0, e_dec);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      ir_m      = 16'h0000;
      reset     = 1'b0;
      mem_rdata = 16'h0000;
      mem_ready = 1'b0;
      cond_true = 1'b0;

      e_fh  = e(3'd0, 1, 0, 0, 1, 2'd0, 0, 0, 0, 0);
      e_fw  = e(3'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
      e_dec = e(3'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
      e_x1  = e(3'd2, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0);
      e_x0  = e(3'd2, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
      e_wb1 = e(3'd5, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
      e_wb0 = e(3'd5, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);

      // addi: four cycles FETCH, DECODE, EXEC, WB
      add_fd(16'h5103);
      add(16'hFFFF, 1'b0, 1'b0, e_x1);
      add(16'hFFFF, 1'b0, 1'b0, e_wb1);
      // load with three wait cycles; ready during DECODE must be ignored
      add(16'h4203, 1'b1, 1'b0, e_fh);
      add(16'h0000, 1'b1, 1'b0, e_dec);
      add(16'h0000, 1'b0, 1'b0, e_x1);
      for (int i = 0; i < 3; i++) add(16'h0000, 1'b0, 1'b0, e(3'd3, 1, 0, 1, 0, 2'd0, 0, 0, 0, 0));
      add(16'h0000, 1'b1, 1'b0, e(3'd3, 1, 0, 1, 0, 2'd0, 1, 0, 1, 0));
      // branch taken
      add_fd(16'hC0FE);
      add(16'h0000, 1'b0, 1'b1, e(3'd2, 0, 0, 0, 1, 2'd1, 0, 1, 0, 0));
      // fetch waits with changing rdata, then branch not taken
      add(16'h1234, 1'b0, 1'b0, e_fw);
      add(16'h5678, 1'b0, 1'b0, e_fw);
      add_fd(16'hC0FE);
      add(16'h0000, 1'b0, 1'b0, e(3'd2, 0, 0, 0, 0, 2'd1, 0, 1, 0, 0));
      // jcond taken through register
      add_fd(16'h42C5);
      add(16'h0000, 1'b0, 1'b1, e(3'd2, 0, 0, 0, 1, 2'd2, 0, 1, 0, 0));
      // R-type add, cond_true high must not move the PC
      add_fd(16'h0700);
      add(16'h0000, 1'b0, 1'b1, e_x0);
      add(16'h0000, 1'b0, 1'b0, e_wb1);
      // R-type compare: no writeback
      add_fd(16'h01B2);
      add(16'h0000, 1'b0, 1'b0, e_x0);
      add(16'h0000, 1'b0, 1'b0, e_wb0);
      // opcode 1000 with register operand, then with immediate
      add_fd(16'h8340);
      add(16'h0000, 1'b0, 1'b0, e_x0);
      add(16'h0000, 1'b0, 1'b0, e_wb1);
      add_fd(16'h8350);
      add(16'h0000, 1'b0, 1'b0, e_x1);
      add(16'h0000, 1'b0, 1'b0, e_wb1);
      // compare immediate: no writeback
      add_fd(16'hB305);
      add(16'h0000, 1'b0, 1'b0, e_x1);
      add(16'h0000, 1'b0, 1'b0, e_wb0);
      // store with one wait cycle
      add_fd(16'h4141);
      add(16'h0000, 1'b0, 1'b0, e_x1);
      add(16'h0000, 1'b0, 1'b0, e(3'd4, 1, 1, 1, 0, 2'd0, 0, 0, 0, 0));
      add(16'h0000, 1'b1, 1'b0, e(3'd4, 1, 1, 1, 0, 2'd0, 0, 0, 0, 0));
      // illegal opext under opcode 0100 -> HALT, absorbing
      add_fd(16'h4F30);
      add(16'h5103, 1'b1, 1'b1, e(3'd6, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1));
      add(16'h5103, 1'b1, 1'b1, e(3'd6, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1));

      do_reset();
      foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i].rdata, vecs[i].rdy, vecs[i].cond, vecs[i].exp);

      // Fetch timeout: 16 waiting cycles (count 0..15), then HALT with fault
      do_reset();
      for (int k = 0; k < 16; k++) apply($sformatf("to_wait%0d", k), 16'h5103, 1'b0, 1'b0, e_fw);
      for (int k = 0; k < 3; k++)
         apply($sformatf("to_halt%0d", k), 16'h5103, 1'b1, 1'b0, e(3'd6, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1));

      // Ready on the cycle the count reaches the limit is a success; then MEMRD timeout
      do_reset();
      for (int k = 0; k < 15; k++) apply($sformatf("edge_wait%0d", k), 16'h4203, 1'b0, 1'b0, e_fw);
      apply("edge_hs", 16'h4203, 1'b1, 1'b0, e_fh);
      apply("edge_dec", 16'h0000, 1'b0, 1'b0, e_dec);
      apply("edge_exec", 16'h0000, 1'b0, 1'b0, e_x1);
      for (int k = 0; k < 16; k++)
         apply($sformatf("rd_wait%0d", k), 16'h0000, 1'b0, 1'b0, e(3'd3, 1, 0, 1, 0, 2'd0, 0, 0, 0, 0));
      apply("rd_halt", 16'h0000, 1'b1, 1'b0, e(3'd6, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1));

      // Reset pulled mid-MEMWR, away from any clock edge
      do_reset();
      apply("wr_fetch", 16'h4141, 1'b1, 1'b0, e_fh);
      apply("wr_dec", 16'h0000, 1'b0, 1'b0, e_dec);
      apply("wr_exec", 16'h0000, 1'b0, 1'b0, e_x1);
      mem_ready = 1'b0;
      #1;
      check("wr_req", 32'(outs()), 32'(e(3'd4, 1, 1, 1, 0, 2'd0, 0, 0, 0, 0)));
      #1;
      reset = 1'b0;
      #1;
      check("rst_async", 32'(outs()), 32'(e(3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0)));
      mem_ready = 1'b1;
      mem_rdata = 16'h5103;
      @(negedge clk);
      #1;
      check("rst_held", 32'(outs()), 32'(e(3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0)));
      check("rst_held_ir", {16'h0, opcode, rdest, opext, rsrc}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      ir_m  = 16'h0000;
      apply("rel_fetch", 16'h6000, 1'b0, 1'b0, e_fw);
      // illegal opcode 0110 afterwards
      apply("ill_fetch", 16'h6000, 1'b1, 1'b0, e_fh);
      apply("ill_dec", 16'h0000, 1'b0, 1'b0, e_dec);
      apply("ill_halt", 16'h0000, 1'b1, 1'b1, e(3'd6, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mcycle_control.md
MCYCLE_CONTROL -- requirements
Module: mcycle_control

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum cycles a memory access waits for mem_ready before abort.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mem_rdata  input  16  memory read data; the instruction word during fetch.
REQ-005 mem_ready  input  1  memory handshake completion, sampled while mem_req=1.
REQ-006 cond_true  input  1  branch/jump condition result from the flag unit, valid in EXEC.
REQ-007 opcode, opext  output  4 each  IR[15:12], IR[7:4]; feed ALU-function decode.
REQ-008 rdest, rsrc  output  4 each  IR[11:8], IR[3:0].
REQ-009 imm  output  8  IR[7:0].
REQ-010 mem_req, mem_we  output  1 each  memory request and write qualifier.
REQ-011 addr_sel  output  1  0 = PC drives the memory address; 1 = register rsrc drives it.
REQ-012 pc_en, pc_src  output  1, 2  PC load enable; pc_src 00 = PC+1, 01 = PC+sign-extended imm, 10 = register rsrc.
REQ-013 regwrite, alusrc_imm, memtoreg  output  1 each  register-file write, immediate ALU operand, load-data writeback.
REQ-014 fault  output  1  sticky: illegal instruction or memory timeout.
REQ-015 state_dbg  output  3  current state encoding.

Function
REQ-016 States: FETCH=0, DECODE=1, EXEC=2, MEMRD=3, MEMWR=4, WB=5, HALT=6.
REQ-017 FETCH: assert mem_req=1, addr_sel=0, mem_we=0; on mem_ready=1, load IR from mem_rdata, pulse pc_en with pc_src=00, then go to DECODE.
REQ-018 IR is written only on a FETCH handshake; opcode/opext/rdest/rsrc/imm are continuous slices of IR.
REQ-019 DECODE: one cycle with no side effects; go to EXEC when the opcode is legal, else set fault and go to HALT.
REQ-020 Legal opcodes: 0000 (R-type), 0001, 0010, 0011, 0101, 1001, 1011, 1101, 1000, 1111, 0100, 1100.
REQ-021 Opcode 0100 subdecode on opext: 0000 = LOAD, 0100 = STOR, 1100 = JCOND; any other opext is illegal.
REQ-022 EXEC, ALU ops: alusrc_imm=1 for every legal opcode except 0000 and (1000 with opext=0100); go to WB.
REQ-023 EXEC, 1100 (Bcond): if cond_true, pc_en=1 with pc_src=01; go to FETCH.
REQ-024 EXEC, JCOND: if cond_true, pc_en=1 with pc_src=10; go to FETCH.
REQ-025 EXEC, LOAD goes to MEMRD; STOR goes to MEMWR.
REQ-026 MEMRD: mem_req=1, addr_sel=1; on mem_ready, regwrite=1 and memtoreg=1 in that same cycle, then go to FETCH.
REQ-027 MEMWR: mem_req=1, mem_we=1, addr_sel=1; on mem_ready, go to FETCH.
REQ-028 WB: regwrite=1 for one cycle, except opcode 1011 and R-type opext 1011 (compare), which keep regwrite=0; go to FETCH.
REQ-029 Wait counter: 4-bit, cleared on entry to FETCH/MEMRD/MEMWR, increments each cycle mem_ready=0 while mem_req=1.
REQ-030 Timeout: when the wait counter reaches WAIT_MAX with no mem_ready, drop mem_req the next cycle, set fault, go to HALT.
REQ-031 mem_ready arriving in the same cycle the counter reaches WAIT_MAX counts as success, not a timeout.
REQ-032 mem_ready while mem_req=0 is ignored.
REQ-033 HALT is absorbing until reset; all strobes are 0 in HALT.
REQ-034 All strobes (mem_req, mem_we, pc_en, regwrite) are Moore/Mealy combinational from the state and registered IR; they are 0 outside their named states.

Reset
REQ-035 Reset assertion at any time, including mid-handshake, forces asynchronously: state=FETCH, IR=0, wait counter=0, fault=0.
REQ-036 While reset is low: mem_req=0, pc_en=0, regwrite=0, mem_we=0.
REQ-037 The first mem_req is asserted in the first clk cycle after reset deasserts.

Structure
REQ-038 State encodings, opcode/opext constants and pc_src codes live in the shared package isa_pkg.
REQ-039 The wait counter with its timeout compare is sub-module mem_wait_timer.

Verification
REQ-040 addi fetch: mem_rdata=16'h5103, mem_ready on the first cycle -> FETCH,DECODE,EXEC,WB; alusrc_imm=1 in EXEC; regwrite=1 in WB; 4 cycles total.
REQ-041 Load: 16'h4203, mem_ready delayed 3 cycles in MEMRD -> mem_req held, addr_sel=1; regwrite and memtoreg pulse together with mem_ready.
REQ-042 Timeout: mem_ready held 0 in FETCH -> wait counter reaches 15, fault=1, state_dbg=6, mem_req=0 thereafter.
REQ-043 Illegal: 16'h0700 is legal R-type; 16'h4F30 (opext 0011) -> fault=1, HALT after DECODE.
REQ-044 Branch: 16'hC0FE with cond_true=1 -> pc_en=1, pc_src=01 in EXEC; with cond_true=0 -> pc_en=0.
REQ-045 Reset mid-MEMWR: reset pulled low while mem_req=1 -> mem_req drops immediately; first mem_req reappears with addr_sel=0 after reset release.
